discriminated_sample_capture: RTL and testbench

// Single-channel capture buffer placed directly downstream of the sample discriminator.

---
 rtl/discriminated_sample_capture_if.sv | 38 +++
 rtl/discriminated_sample_capture.sv | 205 ++++++++++++++++++++
 tb/tb_discriminated_sample_capture.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/discriminated_sample_capture_if.sv
// Capture-buffer signal bundle: realtime sample/timestamp inputs, capture/readout
// control pulses, the AXI-stream style readout port and status outputs.
interface discriminated_sample_capture_if #(
  parameter int DATA_WIDTH   = 256,
  parameter int TSTAMP_WIDTH = 64
) ();
  logic [DATA_WIDTH-1:0]   adc_data_in_data;
  logic                    adc_data_in_valid;
  logic [TSTAMP_WIDTH-1:0] adc_tstamp_in_data;
  logic                    adc_tstamp_in_valid;
  logic                    adc_capture_start;
  logic                    adc_capture_stop;
  logic                    adc_readout_start;
  logic [DATA_WIDTH-1:0]   adc_out_data;
  logic                    adc_out_valid;
  logic                    adc_out_last;
  logic                    adc_out_ready;
  logic                    adc_capture_full;
  logic [1:0]              adc_state;

  modport master (
    output adc_data_in_data, adc_data_in_valid,
    output adc_tstamp_in_data, adc_tstamp_in_valid,
    output adc_capture_start, adc_capture_stop, adc_readout_start,
    output adc_out_ready,
    input  adc_out_data, adc_out_valid, adc_out_last,
    input  adc_capture_full, adc_state
  );

  modport slave (
    input  adc_data_in_data, adc_data_in_valid,
    input  adc_tstamp_in_data, adc_tstamp_in_valid,
    input  adc_capture_start, adc_capture_stop, adc_readout_start,
    input  adc_out_ready,
    output adc_out_data, adc_out_valid, adc_out_last,
    output adc_capture_full, adc_state
  );
endinterface

// File: rtl/discriminated_sample_capture.sv
// Per-channel capture buffer: records discriminated batches and timestamps during a
// capture window, then streams {header, timestamps, batches} as one packet.
module discriminated_sample_capture #(
  parameter int DATA_WIDTH   = 256,
  parameter int TSTAMP_WIDTH = 64,
  parameter int DATA_DEPTH   = 1024,
  parameter int TSTAMP_DEPTH = 256
) (
  input logic                           adc_clk,
  input logic                           adc_reset,
  discriminated_sample_capture_if.slave bus
);
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int TAW = $clog2(TSTAMP_DEPTH);
  localparam int DCW = DAW + 1;
  localparam int TCW = TAW + 1;
  localparam int IW  = ((DCW > TCW) ? DCW : TCW) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, HOLD = 2'd2, READOUT = 2'd3} state_t;
  typedef enum logic [1:0] {K_HDR = 2'd0, K_TS = 2'd1, K_DATA = 2'd2} kind_t;

  state_t state_reg, state_next;

  logic [DATA_WIDTH-1:0]   data_mem [DATA_DEPTH];
  logic [TSTAMP_WIDTH-1:0] ts_mem   [TSTAMP_DEPTH];
  logic [DATA_WIDTH-1:0]   data_rd_reg;
  logic [TSTAMP_WIDTH-1:0] ts_rd_reg;

  logic [DCW-1:0] data_count_reg;
  logic [TCW-1:0] ts_count_reg;
  logic           full_reg;

  logic data_we, ts_we, hit_full, start_capture, start_readout;

  logic [IW-1:0]  issue_idx_reg, total;
  logic [1:0]     occ, occ_after;
  logic           issue_en, issue_last, data_re, ts_re;
  kind_t          issue_kind;
  logic [DAW-1:0] data_rd_addr;
  logic [TAW-1:0] ts_rd_addr;

  logic            pend_valid_reg, pend_last_reg;
  kind_t           pend_kind_reg;
  logic [DATA_WIDTH-1:0] pend_word, header;

  logic                  out_valid_reg, out_last_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  skid_valid_reg, skid_last_reg;
  logic [DATA_WIDTH-1:0] skid_data_reg;
  logic                  pop, done;

  // Capture path: the count guards keep a full memory from wrapping.
  assign data_we  = (state_reg == CAPTURE) && bus.adc_data_in_valid
                    && (data_count_reg != DCW'(DATA_DEPTH));
  assign ts_we    = (state_reg == CAPTURE) && bus.adc_tstamp_in_valid
                    && (ts_count_reg != TCW'(TSTAMP_DEPTH));
  assign hit_full = (data_we && (data_count_reg == DCW'(DATA_DEPTH - 1)))
                 || (ts_we && (ts_count_reg == TCW'(TSTAMP_DEPTH - 1)));

  assign start_readout = (state_reg == HOLD) && bus.adc_readout_start;
  assign start_capture = bus.adc_capture_start
                      && ((state_reg == IDLE) || ((state_reg == HOLD) && !bus.adc_readout_start));

  assign pop  = out_valid_reg && bus.adc_out_ready;
  assign done = pop && out_last_reg;

  always_ff @(posedge adc_clk or posedge adc_reset) begin
    if (adc_reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_capture) state_next = CAPTURE;
      CAPTURE: if (bus.adc_capture_stop || hit_full) state_next = HOLD;
      HOLD: begin
        if (bus.adc_readout_start)      state_next = READOUT;
        else if (bus.adc_capture_start) state_next = CAPTURE;
      end
      READOUT: if (done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge adc_clk or posedge adc_reset) begin
    if (adc_reset) begin
      data_count_reg <= '0;
      ts_count_reg   <= '0;
      full_reg       <= 1'b0;
    end else if (start_capture) begin
      data_count_reg <= '0;
      ts_count_reg   <= '0;
      full_reg       <= 1'b0;
    end else begin
      if (data_we)  data_count_reg <= data_count_reg + DCW'(1);
      if (ts_we)    ts_count_reg   <= ts_count_reg + TCW'(1);
      if (hit_full) full_reg       <= 1'b1;
    end
  end

  // Packet sequencer: index 0 is the header, then timestamps, then batches.
  assign total      = IW'(1) + IW'(ts_count_reg) + IW'(data_count_reg);
  assign issue_last = (issue_idx_reg == total - IW'(1));
  assign occ        = 2'(out_valid_reg) + 2'(skid_valid_reg) + 2'(pend_valid_reg);
  assign occ_after  = occ - 2'(pop);
  // Never more than two words in flight, so the single skid entry cannot overflow.
  assign issue_en   = (state_reg == READOUT) && (issue_idx_reg != total) && (occ_after < 2'd2);

  always_comb begin
    issue_kind = K_DATA;
    if (issue_idx_reg == '0)                     issue_kind = K_HDR;
    else if (issue_idx_reg <= IW'(ts_count_reg)) issue_kind = K_TS;
  end

  assign ts_rd_addr   = TAW'(issue_idx_reg - IW'(1));
  assign data_rd_addr = DAW'(issue_idx_reg - IW'(1) - IW'(ts_count_reg));
  assign ts_re        = issue_en && (issue_kind == K_TS);
  assign data_re      = issue_en && (issue_kind == K_DATA);

  always_ff @(posedge adc_clk) begin
    if (data_we) data_mem[data_count_reg[DAW-1:0]] <= bus.adc_data_in_data;
    if (data_re) data_rd_reg <= data_mem[data_rd_addr];
  end

  always_ff @(posedge adc_clk) begin
    if (ts_we) ts_mem[ts_count_reg[TAW-1:0]] <= bus.adc_tstamp_in_data;
    if (ts_re) ts_rd_reg <= ts_mem[ts_rd_addr];
  end

  always_ff @(posedge adc_clk or posedge adc_reset) begin
    if (adc_reset) begin
      pend_valid_reg <= 1'b0;
      pend_last_reg  <= 1'b0;
      pend_kind_reg  <= K_HDR;
      issue_idx_reg  <= '0;
    end else begin
      pend_valid_reg <= issue_en;
      if (issue_en) begin
        pend_last_reg <= issue_last;
        pend_kind_reg <= issue_kind;
      end
      if (start_readout)  issue_idx_reg <= '0;
      else if (issue_en)  issue_idx_reg <= issue_idx_reg + IW'(1);
    end
  end

  always_comb begin
    header = '0;
    header[DCW-1:0]       = data_count_reg;
    header[DCW+TCW-1:DCW] = ts_count_reg;
  end

  always_comb begin
    case (pend_kind_reg)
      K_HDR:   pend_word = header;
      K_TS:    pend_word = DATA_WIDTH'(ts_rd_reg);
      default: pend_word = data_rd_reg;
    endcase
  end

  // Output register plus one skid entry; the word arriving from memory lands in the
  // skid only when the output is holding a stalled word.
  always_ff @(posedge adc_clk or posedge adc_reset) begin
    if (adc_reset) begin
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      out_data_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_last_reg  <= 1'b0;
      skid_data_reg  <= '0;
    end else if (!out_valid_reg || pop) begin
      if (skid_valid_reg) begin
        out_valid_reg  <= 1'b1;
        out_data_reg   <= skid_data_reg;
        out_last_reg   <= skid_last_reg;
        skid_valid_reg <= pend_valid_reg;
        if (pend_valid_reg) begin
          skid_data_reg <= pend_word;
          skid_last_reg <= pend_last_reg;
        end
      end else if (pend_valid_reg) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= pend_word;
        out_last_reg  <= pend_last_reg;
      end else begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end
    end else if (pend_valid_reg) begin
      skid_valid_reg <= 1'b1;
      skid_data_reg  <= pend_word;
      skid_last_reg  <= pend_last_reg;
    end
  end

  assign bus.adc_out_data     = out_data_reg;
  assign bus.adc_out_valid    = out_valid_reg;
  assign bus.adc_out_last     = out_last_reg;
  assign bus.adc_capture_full = full_reg;
  assign bus.adc_state        = state_reg;
endmodule

// File: tb/tb_discriminated_sample_capture.sv
// Bench for discriminated_sample_capture: table of capture scenarios replayed through a
// scoreboard of expected packet words, plus hand-written tie-break and reset sequences.
module tb_discriminated_sample_capture;
  localparam int DW = 64;
  localparam int TW = 32;
  localparam int DD = 16;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  discriminated_sample_capture_if #(.DATA_WIDTH(DW), .TSTAMP_WIDTH(TW)) bus ();

  discriminated_sample_capture #(
    .DATA_WIDTH(DW), .TSTAMP_WIDTH(TW), .DATA_DEPTH(DD), .TSTAMP_DEPTH(TD)
  ) dut (
    .adc_clk(clk),
    .adc_reset(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  typedef struct {
    int nd;
    int nt;
    bit stop_same;
    bit rnd;
    bit tie;
    bit exp_full;
    int exp_tc;
    int exp_dc;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_count = 0;

  logic          rdy_rand = 1'b0;
  logic [15:0]   rdy_pat  = 16'b0110_1101_1010_1001;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: the handshake is predicted here and completes on the next edge.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 64'(bus.adc_out_valid), 64'(1));
        check("stall_data", bus.adc_out_data, prev_data);
        check("stall_last", 64'(bus.adc_out_last), 64'(prev_last));
      end
      if (bus.adc_out_valid && bus.adc_out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(exp_q.size()), 64'(1));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word_data", bus.adc_out_data, e.data);
          check("word_last", 64'(bus.adc_out_last), 64'(e.last));
          hs_count++;
        end
      end
      stall_prev = bus.adc_out_valid && !bus.adc_out_ready;
      prev_data  = bus.adc_out_data;
      prev_last  = bus.adc_out_last;
    end
  end

  initial begin
    int k;
    k = 0;
    bus.adc_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) begin
        bus.adc_out_ready = rdy_pat[k % 16];
        k++;
      end else begin
        bus.adc_out_ready = 1'b1;
      end
    end
  end

  task automatic push_packet(input int tc, input int dc);
    int n;
    exp_t e;
    n = 1 + tc + dc;
    e.data = (DW'(tc) << 5) | DW'(dc);
    e.last = (n == 1);
    exp_q.push_back(e);
    for (int i = 0; i < tc; i++) begin
      e.data = DW'(TW'(32'hA + i));
      e.last = (1 + i == n - 1);
      exp_q.push_back(e);
    end
    for (int i = 0; i < dc; i++) begin
      e.data = DW'(i + 1);
      e.last = (1 + tc + i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_capture(input vec_t v);
    int ncyc;
    ncyc = (v.nd > v.nt) ? v.nd : v.nt;
    bus.adc_capture_start = 1'b1;
    tick();
    bus.adc_capture_start = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      bus.adc_data_in_valid   = (i < v.nd);
      bus.adc_data_in_data    = DW'(i + 1);
      bus.adc_tstamp_in_valid = (i < v.nt);
      bus.adc_tstamp_in_data  = TW'(32'hA + i);
      bus.adc_capture_stop    = v.stop_same && (i == ncyc - 1);
      tick();
    end
    bus.adc_data_in_valid   = 1'b0;
    bus.adc_tstamp_in_valid = 1'b0;
    bus.adc_capture_stop    = 1'b0;
    if (!v.stop_same || ncyc == 0) begin
      bus.adc_capture_stop = 1'b1;
      tick();
      bus.adc_capture_stop = 1'b0;
    end
    tick();
    check("hold_state", 64'(bus.adc_state), 64'(2));
    check("capture_full", 64'(bus.adc_capture_full), 64'(v.exp_full));
  endtask

  task automatic run_readout(input vec_t v);
    int lat;
    int g;
    push_packet(v.exp_tc, v.exp_dc);
    rdy_rand = v.rnd;
    bus.adc_readout_start = 1'b1;
    bus.adc_capture_start = v.tie;
    tick();
    bus.adc_readout_start = 1'b0;
    bus.adc_capture_start = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!bus.adc_out_valid && lat < 5) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat > 3) begin
      errors++;
      $display("FAIL first_valid_latency: got %0d cycles, expected at most 3", lat);
    end
    g = 0;
    do begin
      @(posedge clk);
      g++;
    end while (exp_q.size() != 0 && g < 400);
    #1;
    check("readout_drained", 64'(exp_q.size()), 64'(0));
    check("idle_after_last", 64'(bus.adc_state), 64'(0));
    check("full_after_readout", 64'(bus.adc_capture_full), 64'(v.exp_full));
    exp_q.delete();
    rdy_rand = 1'b0;
    tick();
  endtask

  initial begin
    vec_t vecs[7];
    int   g;

    vecs[0] = '{5,  2, 1'b1, 1'b0, 1'b0, 1'b0, 2, 5};
    vecs[1] = '{20, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 16};
    vecs[2] = '{0,  6, 1'b0, 1'b0, 1'b0, 1'b1, 4, 0};
    vecs[3] = '{0,  0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[4] = '{18, 6, 1'b0, 1'b0, 1'b0, 1'b1, 4, 4};
    vecs[5] = '{5,  2, 1'b0, 1'b1, 1'b0, 1'b0, 2, 5};
    vecs[6] = '{3,  1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 3};

    bus.adc_data_in_data    = '0;
    bus.adc_data_in_valid   = 1'b0;
    bus.adc_tstamp_in_data  = '0;
    bus.adc_tstamp_in_valid = 1'b0;
    bus.adc_capture_start   = 1'b0;
    bus.adc_capture_stop    = 1'b0;
    bus.adc_readout_start   = 1'b0;

    rst = 1'b1;
    repeat (3) tick();
    check("reset_state", 64'(bus.adc_state), 64'(0));
    check("reset_valid", 64'(bus.adc_out_valid), 64'(0));
    check("reset_last", 64'(bus.adc_out_last), 64'(0));
    check("reset_full", 64'(bus.adc_capture_full), 64'(0));
    check("reset_data", bus.adc_out_data, 64'(0));
    rst = 1'b0;
    tick();

    for (int r = 0; r < 7; r++) begin
      $display("row %0d: nd=%0d nt=%0d rnd=%0d tie=%0d", r, vecs[r].nd, vecs[r].nt,
               vecs[r].rnd, vecs[r].tie);
      run_capture(vecs[r]);
      run_readout(vecs[r]);
    end

    // Reset in the middle of a readout, then a readout request with nothing captured.
    run_capture(vecs[0]);
    push_packet(2, 5);
    hs_count = 0;
    bus.adc_readout_start = 1'b1;
    tick();
    bus.adc_readout_start = 1'b0;
    g = 0;
    while (hs_count < 3 && g < 100) begin
      @(posedge clk);
      g++;
    end
    #1;
    rst = 1'b1;
    #1;
    check("third_word_seen", 64'(hs_count), 64'(3));
    check("midreset_valid", 64'(bus.adc_out_valid), 64'(0));
    check("midreset_state", 64'(bus.adc_state), 64'(0));
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    bus.adc_readout_start = 1'b1;
    tick();
    bus.adc_readout_start = 1'b0;
    repeat (10) tick();
    check("idle_readout_state", 64'(bus.adc_state), 64'(0));
    check("idle_readout_valid", 64'(bus.adc_out_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
